// File: rtl/bnn_pe_pkg.sv
// Shared definitions for the binary (XNOR) PE column and its feeder.
package bnn_pe_pkg;

  // Default column geometry, also used by the PE array top.
  localparam int DEF_KERNEL = 9;
  localparam int DEF_ROWS   = 16;

  // Feeder sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/xnor_pe_feeder.sv
// Transmit side of the XNOR PE weight chain and activation interface.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | cfg_ready high, waiting for a kernel weight word
// LOAD_W   | shifting KERNEL weight bits into the chain, MSB first
// STREAM   | act_ready high, one PE beat per accepted activation
// DRAIN    | KERNEL cycles of en with no start, flushing popcounts
// DONE     | last drain cycle issued; done pulses on the next cycle
//
// All PE pins are registered: every pin value reflects the decision made
// at the previous clock edge. The done pulse is issued while the FSM is
// already back in IDLE, which is why cfg_ready only returns one cycle later.
module xnor_pe_feeder
  import bnn_pe_pkg::*;
#(
  parameter int KERNEL = DEF_KERNEL,
  parameter int ROWS   = DEF_ROWS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [KERNEL-1:0] cfg_weights,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic              act_bit,
  input  logic              act_last,
  output logic              en,
  output logic              weight_control,
  output logic              weight_in,
  output logic              intop,
  output logic              top_start,
  output logic              start,
  output logic              top_control,
  output logic              side_control,
  output logic              done,
  output logic              err_overrun
);

  localparam int PW = $clog2(KERNEL + 1);
  localparam int BW = $clog2(ROWS + 1);
  localparam logic [PW-1:0] PHASE_INIT = PW'(KERNEL - 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(ROWS - 1);

  state_t            state;
  // Only the bits still to be sent; the MSB goes straight to weight_in.
  logic [KERNEL-2:0] wsr;
  logic [PW-1:0]     phase;
  logic [BW-1:0]     beats;
  logic              final_beat;

  // The ROWS-th accepted beat closes the frame whether or not it is marked last.
  assign final_beat = act_last || (beats == LAST_BEAT);

  // Sequencer, counters and all registered PE pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      wsr            <= '0;
      phase          <= '0;
      beats          <= '0;
      cfg_ready      <= 1'b1;
      act_ready      <= 1'b0;
      en             <= 1'b0;
      weight_control <= 1'b0;
      weight_in      <= 1'b0;
      intop          <= 1'b0;
      top_start      <= 1'b0;
      start          <= 1'b0;
      top_control    <= 1'b0;
      side_control   <= 1'b0;
      done           <= 1'b0;
      err_overrun    <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_overrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_valid && cfg_ready) begin
            state          <= ST_LOAD_W;
            wsr            <= cfg_weights[KERNEL-2:0];
            phase          <= PHASE_INIT;
            cfg_ready      <= 1'b0;
            en             <= 1'b1;
            weight_control <= 1'b1;
            weight_in      <= cfg_weights[KERNEL-1];
          end else begin
            cfg_ready <= 1'b1;
          end
        end

        ST_LOAD_W: begin
          if (phase == '0) begin
            state          <= ST_STREAM;
            en             <= 1'b0;
            weight_control <= 1'b0;
            weight_in      <= 1'b0;
            act_ready      <= 1'b1;
            beats          <= '0;
          end else begin
            phase     <= phase - 1'b1;
            weight_in <= wsr[KERNEL-2];
            wsr       <= wsr << 1;
          end
        end

        ST_STREAM: begin
          en           <= 1'b0;
          start        <= 1'b0;
          top_control  <= 1'b0;
          intop        <= 1'b0;
          top_start    <= 1'b0;
          side_control <= 1'b0;
          if (act_valid) begin
            en           <= 1'b1;
            start        <= 1'b1;
            top_control  <= 1'b1;
            intop        <= act_bit;
            top_start    <= (beats == '0);
            side_control <= (beats != '0);
            beats        <= beats + 1'b1;
            if (final_beat) begin
              state       <= ST_DRAIN;
              act_ready   <= 1'b0;
              phase       <= PHASE_INIT;
              err_overrun <= !act_last;
            end
          end
        end

        ST_DRAIN: begin
          en           <= 1'b1;
          start        <= 1'b0;
          top_control  <= 1'b0;
          intop        <= 1'b0;
          top_start    <= 1'b0;
          side_control <= 1'b0;
          if (phase == '0) begin
            state <= ST_DONE;
          end else begin
            phase <= phase - 1'b1;
          end
        end

        ST_DONE: begin
          en    <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
